// File: rtl/sal_timing_regs_pkg.sv
// sal_timing_regs_pkg: register map, update FSM states and reset timing defaults
`ifndef T_RCD_VALUE
`define T_RCD_VALUE 4
`define T_RP_VALUE 4
`define T_RAS_VALUE 12
`define T_RFC_VALUE 51
`define T_RTP_VALUE 3
`define T_WTP_VALUE 9
`define T_RRD_VALUE 3
`define T_CCD_VALUE 2
`define T_WTR_VALUE 3
`define T_RTW_VALUE 4
`endif
package sal_timing_regs_pkg;
  localparam int NF = 10;
  localparam logic [7:0] OFF_CTRL = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_SHADOW = 8'h10;
  localparam logic [7:0] OFF_LAST = 8'h34;
  typedef enum logic [1:0] {IDLE, PEND, APPLY} state_e;
  typedef enum logic [3:0] {F_RCD, F_RP, F_RAS, F_RFC, F_RTP, F_WTP, F_RRD, F_CCD, F_WTR, F_RTW} field_e;
  // rcd is declared last so it lands in the low slot and slot i matches field_e
  typedef struct packed {
    logic [31:0] rtw, wtr, ccd, rrd, wtp, rtp, rfc, ras, rp, rcd;
  } timing_t;
  localparam timing_t T_DEFAULT = '{
    rtw: 32'(`T_RTW_VALUE), wtr: 32'(`T_WTR_VALUE), ccd: 32'(`T_CCD_VALUE),
    rrd: 32'(`T_RRD_VALUE), wtp: 32'(`T_WTP_VALUE), rtp: 32'(`T_RTP_VALUE),
    rfc: 32'(`T_RFC_VALUE), ras: 32'(`T_RAS_VALUE), rp: 32'(`T_RP_VALUE),
    rcd: 32'(`T_RCD_VALUE)};
  function automatic logic [31:0] t_default(input int i);
    logic [NF-1:0][31:0] v;
    v = T_DEFAULT;
    return v[i];
  endfunction
endpackage

// File: rtl/sal_timing_regs_if.sv
// sal_timing_regs_if: APB slave link and the bank/scheduler timing output bundles
interface apb_if #(parameter int AW = 8);
  logic psel, penable, pwrite, pready, pslverr;
  logic [AW-1:0] paddr;
  logic [31:0] pwdata, prdata;
  modport slave(input psel, penable, pwrite, paddr, pwdata, output prdata, pready, pslverr);
endinterface

interface bk_timing_if #(parameter int TW = 8);
  logic [TW-1:0] t_rcd, t_rp, t_ras, t_rfc, t_rtp, t_wtp;
  modport src(output t_rcd, t_rp, t_ras, t_rfc, t_rtp, t_wtp);
endinterface

interface sched_timing_if #(parameter int TW = 8);
  logic [TW-1:0] t_rrd, t_ccd, t_wtr, t_rtw;
  modport src(output t_rrd, t_ccd, t_wtr, t_rtw);
endinterface

// File: rtl/sal_apb_regdec.sv
// sal_apb_regdec: APB address decode, write strobes, error detection and read mux
module sal_apb_regdec
  import sal_timing_regs_pkg::*;
#(
  parameter int TW = 8,
  parameter int AW = 8
) (
  input  logic                   psel,
  input  logic                   penable,
  input  logic                   pwrite,
  input  logic [AW-1:0]          paddr,
  input  logic [TW-1:0]          wfield,
  input  logic [NF-1:0][TW-1:0]  shadow,
  input  logic [2:0]             status,
  output logic                   ctrl_we,
  output logic                   status_we,
  output logic                   shadow_we,
  output logic [3:0]             shadow_idx,
  output logic [31:0]            prdata,
  output logic                   pslverr
);
  logic acc, is_ctrl, is_stat, is_sh, sh_bad;
  always_comb begin
    acc = psel & penable;
    is_ctrl = paddr == AW'(OFF_CTRL);
    is_stat = paddr == AW'(OFF_STATUS);
    is_sh = paddr[1:0] == 2'b00 && paddr >= AW'(OFF_SHADOW) && paddr <= AW'(OFF_LAST);
    shadow_idx = paddr[5:2] - 4'd4;
    // status[1:0] are LOCKED and PENDING: either blocks shadow writes
    sh_bad = wfield == '0 || status[1:0] != 2'b00;
    ctrl_we = acc & pwrite & is_ctrl;
    status_we = acc & pwrite & is_stat;
    shadow_we = acc & pwrite & is_sh & ~sh_bad;
    pslverr = acc & (~(is_ctrl | is_stat | is_sh) | (pwrite & is_sh & sh_bad));
    prdata = (!acc || pwrite) ? '0 : is_stat ? 32'(status) : is_sh ? 32'(shadow[shadow_idx]) : '0;
  end
endmodule

// File: rtl/sal_timing_regs.sv
// sal_timing_regs: APB-programmed DDR2 timing shadows, applied to active outputs when the scheduler idles
module sal_timing_regs
  import sal_timing_regs_pkg::*;
#(
  parameter int TW = 8,
  parameter int AW = 8,
  parameter int UPD_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  apb_if.slave               apb_intf,
  bk_timing_if.src           bk_timing_intf,
  sched_timing_if.src        sched_timing_intf,
  input  logic               sched_idle,
  output logic               cfg_updated
);
  localparam int CW = $clog2(UPD_TIMEOUT + 1);
  state_e state, state_nx;
  logic [CW-1:0] cnt;
  logic [NF-1:0][TW-1:0] shadow, active;
  logic locked, timeout, pending, tmo_hit, upd_req;
  logic ctrl_we, status_we, shadow_we;
  logic [3:0] shadow_idx;

  sal_apb_regdec #(.TW(TW), .AW(AW)) u_regdec (
    .psel       (apb_intf.psel),
    .penable    (apb_intf.penable),
    .pwrite     (apb_intf.pwrite),
    .paddr      (apb_intf.paddr),
    .wfield     (apb_intf.pwdata[TW-1:0]),
    .shadow     (shadow),
    .status     ({timeout, locked, pending}),
    .ctrl_we    (ctrl_we),
    .status_we  (status_we),
    .shadow_we  (shadow_we),
    .shadow_idx (shadow_idx),
    .prdata     (apb_intf.prdata),
    .pslverr    (apb_intf.pslverr)
  );
  assign apb_intf.pready = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end

  // UPDATE always lands in PEND first, even if sched_idle is already high
  always_comb begin
    state_nx = state == IDLE ? (upd_req ? PEND : IDLE)
             : state == PEND ? (sched_idle ? APPLY : tmo_hit ? IDLE : PEND)
             : IDLE;
  end

  always_comb begin
    pending = state != IDLE;
    tmo_hit = state == PEND && !sched_idle && cnt == CW'(UPD_TIMEOUT);
    upd_req = ctrl_we && apb_intf.pwdata[0] && !pending;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      locked <= 1'b0;
      timeout <= 1'b0;
      cfg_updated <= 1'b0;
      for (int i = 0; i < NF; i++) begin
        shadow[i] <= TW'(t_default(i));
        active[i] <= TW'(t_default(i));
      end
    end else begin
      cnt <= state != PEND ? '0 : cnt == CW'(UPD_TIMEOUT) ? cnt : cnt + 1'b1;
      locked <= locked | (ctrl_we & apb_intf.pwdata[1]);
      timeout <= tmo_hit | (timeout & ~(status_we & apb_intf.pwdata[2]));
      cfg_updated <= state == APPLY;
      if (shadow_we) shadow[shadow_idx] <= apb_intf.pwdata[TW-1:0];
      if (state == APPLY) active <= shadow;
    end
  end

  assign bk_timing_intf.t_rcd = active[F_RCD];
  assign bk_timing_intf.t_rp = active[F_RP];
  assign bk_timing_intf.t_ras = active[F_RAS];
  assign bk_timing_intf.t_rfc = active[F_RFC];
  assign bk_timing_intf.t_rtp = active[F_RTP];
  assign bk_timing_intf.t_wtp = active[F_WTP];
  assign sched_timing_intf.t_rrd = active[F_RRD];
  assign sched_timing_intf.t_ccd = active[F_CCD];
  assign sched_timing_intf.t_wtr = active[F_WTR];
  assign sched_timing_intf.t_rtw = active[F_RTW];
endmodule

// File: tb/tb_sal_timing_regs.sv
// tb_sal_timing_regs: scoreboard bench for the timing register block
module tb_sal_timing_regs;
  logic clk = 1'b0, rst_n = 1'b0, sched_idle = 1'b0, cfg_updated;
  int checks = 0, errors = 0;
  typedef struct packed {logic [31:0] data; logic err;} rsp_t;
  rsp_t exp_q[$], obs_q[$];
  localparam logic [9:0][7:0] DFLT = {8'd4, 8'd3, 8'd2, 8'd3, 8'd9, 8'd3, 8'd51, 8'd12, 8'd4, 8'd4};

  apb_if #(.AW(8)) apb();
  bk_timing_if #(.TW(8)) bk();
  sched_timing_if #(.TW(8)) sch();

  sal_timing_regs #(.TW(8), .AW(8), .UPD_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .apb_intf(apb), .bk_timing_intf(bk),
    .sched_timing_intf(sch), .sched_idle(sched_idle), .cfg_updated(cfg_updated)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic xfer(input logic wr, input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = wr; apb.paddr = a; apb.pwdata = d;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    @(negedge clk);
    obs_q.push_back({apb.prdata, apb.pslverr});
    @(posedge clk); #1;
    apb.psel = 1'b0; apb.penable = 1'b0;
  endtask

  task automatic test_reset();
    rsp_t e, o;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = '0; apb.pwdata = '0;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({bk.t_rcd, bk.t_rp, bk.t_ras, bk.t_rfc, bk.t_rtp, bk.t_wtp} !== {DFLT[0], DFLT[1], DFLT[2], DFLT[3], DFLT[4], DFLT[5]}) begin
      errors++;
      $display("FAIL reset_bk: got %h want %h", {bk.t_rcd, bk.t_rp, bk.t_ras, bk.t_rfc, bk.t_rtp, bk.t_wtp},
               {DFLT[0], DFLT[1], DFLT[2], DFLT[3], DFLT[4], DFLT[5]});
    end
    checks++;
    if ({sch.t_rrd, sch.t_ccd, sch.t_wtr, sch.t_rtw} !== {DFLT[6], DFLT[7], DFLT[8], DFLT[9]}) begin
      errors++;
      $display("FAIL reset_sched: got %h want %h", {sch.t_rrd, sch.t_ccd, sch.t_wtr, sch.t_rtw}, {DFLT[6], DFLT[7], DFLT[8], DFLT[9]});
    end
    checks++;
    if ({cfg_updated, apb.pslverr, apb.prdata, apb.pready} !== {1'b0, 1'b0, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL reset_ctl: got cfg=%b err=%b prdata=%h pready=%b want 0 0 0 1", cfg_updated, apb.pslverr, apb.prdata, apb.pready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.push_back({32'h0, 1'b0}); xfer(1'b0, 8'h04, 32'h0);
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back({24'h0, DFLT[i], 1'b0});
      xfer(1'b0, 8'(8'h10 + 4 * i), 32'h0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_apb: got data=%h err=%b want data=%h err=%b", o.data, o.err, e.data, e.err);
      end
    end
  endtask

  task automatic test_update();
    rsp_t e, o;
    logic [7:0] t_at [5];
    logic c_at [5];
    int pulses;
    sched_idle = 1'b0;
    exp_q.push_back({32'h0, 1'b0}); xfer(1'b1, 8'h10, 32'h07);
    exp_q.push_back({32'h0, 1'b0}); xfer(1'b1, 8'h00, 32'h1);
    exp_q.push_back({32'h1, 1'b0}); xfer(1'b0, 8'h04, 32'h0);
    checks++;
    if (bk.t_rcd !== 8'h04) begin
      errors++;
      $display("FAIL update_hold: t_rcd=%h want 04", bk.t_rcd);
    end
    sched_idle = 1'b1;
    pulses = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      t_at[n] = bk.t_rcd; c_at[n] = cfg_updated;
      pulses += int'(cfg_updated);
    end
    sched_idle = 1'b0;
    checks++;
    if ({t_at[1], t_at[2], c_at[2]} !== {8'h04, 8'h07, 1'b1}) begin
      errors++;
      $display("FAIL update_apply: got t1=%h t2=%h cfg2=%b want 04 07 1", t_at[1], t_at[2], c_at[2]);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL update_pulse: got %0d pulses want 1", pulses);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL update_apb: got data=%h err=%b want data=%h err=%b", o.data, o.err, e.data, e.err);
      end
    end
  endtask

  task automatic test_bad_access();
    rsp_t e, o;
    exp_q.push_back({32'h0, 1'b1}); xfer(1'b1, 8'h18, 32'h100);
    exp_q.push_back({32'd12, 1'b0}); xfer(1'b0, 8'h18, 32'h0);
    exp_q.push_back({32'h0, 1'b0}); xfer(1'b1, 8'h1C, 32'h120);
    exp_q.push_back({32'h20, 1'b0}); xfer(1'b0, 8'h1C, 32'h0);
    exp_q.push_back({32'h0, 1'b1}); xfer(1'b1, 8'h3C, 32'h55);
    exp_q.push_back({32'h0, 1'b1}); xfer(1'b0, 8'h3C, 32'h0);
    exp_q.push_back({32'h0, 1'b1}); xfer(1'b0, 8'h11, 32'h0);
    exp_q.push_back({32'h0, 1'b0}); xfer(1'b0, 8'h00, 32'h0);
    checks++;
    if (bk.t_rfc !== 8'd51) begin
      errors++;
      $display("FAIL shadow_only: t_rfc=%h want 33", bk.t_rfc);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL bad_access_apb: got data=%h err=%b want data=%h err=%b", o.data, o.err, e.data, e.err);
      end
    end
  endtask

  task automatic test_same_cycle();
    rsp_t e, o;
    logic [7:0] r_at [3];
    logic c_at [3];
    exp_q.push_back({32'h0, 1'b0}); xfer(1'b1, 8'h34, 32'h0A);
    sched_idle = 1'b1;
    exp_q.push_back({32'h0, 1'b0}); xfer(1'b1, 8'h00, 32'h1);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      r_at[n] = sch.t_rtw; c_at[n] = cfg_updated;
    end
    sched_idle = 1'b0;
    checks++;
    if ({r_at[1], c_at[1], r_at[2], c_at[2], bk.t_rfc} !== {8'h04, 1'b0, 8'h0A, 1'b1, 8'h20}) begin
      errors++;
      $display("FAIL same_cycle: got rtw1=%h cfg1=%b rtw2=%h cfg2=%b rfc=%h want 04 0 0a 1 20",
               r_at[1], c_at[1], r_at[2], c_at[2], bk.t_rfc);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL same_cycle_apb: got data=%h err=%b want data=%h err=%b", o.data, o.err, e.data, e.err);
      end
    end
  endtask

  task automatic test_timeout();
    rsp_t e, o;
    sched_idle = 1'b0;
    exp_q.push_back({32'h0, 1'b0}); xfer(1'b1, 8'h30, 32'h06);
    exp_q.push_back({32'h0, 1'b0}); xfer(1'b1, 8'h00, 32'h1);
    exp_q.push_back({32'h0, 1'b1}); xfer(1'b1, 8'h10, 32'h09);
    exp_q.push_back({32'h4, 1'b0}); xfer(1'b0, 8'h04, 32'h0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bk.t_rcd, sch.t_wtr, cfg_updated} !== {8'h07, 8'h03, 1'b0}) begin
      errors++;
      $display("FAIL timeout_outputs: got rcd=%h wtr=%h cfg=%b want 07 03 0", bk.t_rcd, sch.t_wtr, cfg_updated);
    end
    exp_q.push_back({32'h4, 1'b0}); xfer(1'b0, 8'h04, 32'h0);
    exp_q.push_back({32'h0, 1'b0}); xfer(1'b1, 8'h04, 32'h4);
    exp_q.push_back({32'h0, 1'b0}); xfer(1'b0, 8'h04, 32'h0);
    exp_q.push_back({32'h7, 1'b0}); xfer(1'b0, 8'h10, 32'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL timeout_apb: got data=%h err=%b want data=%h err=%b", o.data, o.err, e.data, e.err);
      end
    end
  endtask

  task automatic test_lock();
    rsp_t e, o;
    int pulses;
    sched_idle = 1'b1;
    exp_q.push_back({32'h0, 1'b0}); xfer(1'b1, 8'h00, 32'h3);
    pulses = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      pulses += int'(cfg_updated);
    end
    sched_idle = 1'b0;
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL lock_update: got %0d pulses want 1", pulses);
    end
    exp_q.push_back({32'h0, 1'b1}); xfer(1'b1, 8'h14, 32'h05);
    exp_q.push_back({32'h2, 1'b0}); xfer(1'b0, 8'h04, 32'h0);
    exp_q.push_back({32'h0, 1'b0}); xfer(1'b1, 8'h00, 32'h0);
    exp_q.push_back({32'h2, 1'b0}); xfer(1'b0, 8'h04, 32'h0);
    exp_q.push_back({32'h4, 1'b0}); xfer(1'b0, 8'h14, 32'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL lock_apb: got data=%h err=%b want data=%h err=%b", o.data, o.err, e.data, e.err);
      end
    end
  endtask

  task automatic test_reset_abort();
    rsp_t e, o;
    sched_idle = 1'b0;
    exp_q.push_back({32'h0, 1'b0}); xfer(1'b1, 8'h00, 32'h1);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({bk.t_rcd, sch.t_rtw, bk.t_rfc, cfg_updated} !== {DFLT[0], DFLT[9], DFLT[3], 1'b0}) begin
      errors++;
      $display("FAIL reset_abort: got rcd=%h rtw=%h rfc=%h cfg=%b want %h %h %h 0",
               bk.t_rcd, sch.t_rtw, bk.t_rfc, cfg_updated, DFLT[0], DFLT[9], DFLT[3]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.push_back({32'h0, 1'b0}); xfer(1'b0, 8'h04, 32'h0);
    exp_q.push_back({24'h0, DFLT[0], 1'b0}); xfer(1'b0, 8'h10, 32'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_abort_apb: got data=%h err=%b want data=%h err=%b", o.data, o.err, e.data, e.err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_update();
    test_bad_access();
    test_same_cycle();
    test_timeout();
    test_lock();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sal_timing_regs.md
SAL_TIMING_REGS -- requirements
Module: SAL_TIMING_REGS

Interface
REQ-001 The block SHALL have parameter TW, default 8, giving the width of every timing field.
REQ-002 The block SHALL have parameter AW, default 8, giving the width of PADDR that the block decodes.
REQ-003 The block SHALL have parameter UPD_TIMEOUT, default 1024, giving the maximum number of cycles an update waits for sched_idle.
REQ-004 Port clk SHALL be an input, 1 bit: the single clock.
REQ-005 Port rst_n SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-006 Port apb_intf SHALL be an APB_INTF slave (PSEL, PENABLE, PWRITE, PADDR[AW-1:0], PWDATA[31:0], PRDATA[31:0], PREADY, PSLVERR).
REQ-007 Port bk_timing_intf SHALL be an output: active t_rcd, t_rp, t_ras, t_rfc, t_rtp, t_wtp, each TW bits.
REQ-008 Port sched_timing_intf SHALL be an output: active t_rrd, t_ccd, t_wtr, t_rtw, each TW bits.
REQ-009 Port sched_idle SHALL be an input, 1 bit: the scheduler has no command in flight and all banks are precharged.
REQ-010 Port cfg_updated SHALL be an output, 1 bit: a one-cycle pulse when the active timings change.

Function
REQ-011 APB SHALL have zero wait states: PREADY=1 always; a write or read takes effect in the access phase (PSEL&PENABLE).
REQ-012 Address map (byte addresses) SHALL be:
- 0x00 CTRL, write-only: bit0 UPDATE (write-1 pulse); bit1 LOCK (write-1, sticky).
- 0x04 STATUS, read-only: bit0 PENDING, bit1 LOCKED, bit2 TIMEOUT (sticky, cleared by writing 1 to STATUS bit2).
- 0x10..0x34 shadow registers at stride 4, in the order RCD, RP, RAS, RFC, RTP, WTP, RRD, CCD, WTR, RTW.
REQ-013 A read of a shadow register SHALL return the shadow value zero-extended to 32 bits; a read of CTRL SHALL return 0.
REQ-014 A shadow write SHALL store PWDATA[TW-1:0] and ignore the upper bits.
REQ-015 A shadow write SHALL assert PSLVERR and leave the register unchanged when:
- PWDATA[TW-1:0]==0, or
- LOCKED=1, or
- PENDING=1.
REQ-016 An access to an unmapped address SHALL assert PSLVERR, return PRDATA=0 and change no state.
REQ-017 Active registers SHALL change only in state APPLY; the outputs SHALL be the active registers driven directly from flops.
REQ-018 The update FSM SHALL have states IDLE, PEND and APPLY:
- IDLE->PEND on a write of UPDATE=1.
- PEND->APPLY when sched_idle=1.
- APPLY->IDLE unconditionally after 1 cycle.
REQ-019 In APPLY, active<=shadow for all ten fields, and cfg_updated=1 on the following cycle, for exactly 1 cycle.
REQ-020 PENDING SHALL be 1 while in PEND or APPLY.
REQ-021 A write of UPDATE=1 while PENDING=1 SHALL be ignored without PSLVERR.
REQ-022 A write of UPDATE=1 while LOCKED=1 SHALL be accepted, so a locked configuration can be re-applied.
REQ-023 If UPDATE=1 and sched_idle=1 are present in the same cycle, the FSM SHALL still pass through PEND, so the minimum latency from the UPDATE access to the active change is 2 cycles.
REQ-024 PEND SHALL run a wait counter of width clog2(UPD_TIMEOUT+1); on reaching UPD_TIMEOUT, the FSM SHALL set TIMEOUT, return to IDLE and leave the active registers unchanged.
REQ-025 The wait counter SHALL saturate and SHALL clear on entry to PEND.
REQ-026 LOCK SHALL be cleared only by reset; a write of LOCK=0 SHALL have no effect.
REQ-027 A single CTRL write with LOCK=1 and UPDATE=1 SHALL set LOCK and start the update.

Reset
REQ-028 On rst_n low (asynchronous), the shadow and active registers SHALL take the `T_*_VALUE macros from SAL_DDR2_PARAMS.svh, truncated to TW bits.
REQ-029 On reset the FSM SHALL be IDLE, LOCKED=0, TIMEOUT=0, counter=0, cfg_updated=0, PSLVERR=0 and PRDATA=0.
REQ-030 Reset asserted while in PEND or APPLY SHALL abort the update; the active registers SHALL return to the macro defaults.

Structure
REQ-031 The shared package SHALL hold the register offset constants, the FSM state enum, and a typedef struct of the ten TW-wide timing fields.
REQ-032 The APB address decode and read mux SHALL sit in one sub-module, SAL_APB_REGDEC.
REQ-033 The FSM, the counter and the shadow/active storage SHALL sit in the top level.

Verification
REQ-034 Reset check: the outputs SHALL equal the macro defaults and STATUS SHALL read 0x0.
REQ-035 Write RCD=0x07 with sched_idle=0, then UPDATE: t_rcd SHALL be unchanged and PENDING=1; raise sched_idle: t_rcd=0x07 two cycles later, and cfg_updated SHALL pulse once.
REQ-036 Write RAS=0x00 -> PSLVERR=1 and a read of 0x18 SHALL return the old value.
REQ-037 Write to 0x3C -> PSLVERR=1 and PRDATA=0.
REQ-038 Set LOCK, then write RP=0x05 -> PSLVERR=1; STATUS=0x2.
REQ-039 Set UPD_TIMEOUT=4, UPDATE with sched_idle=0 for 10 cycles -> STATUS=0x4 after 5 cycles and the outputs SHALL be unchanged; a shadow write during PEND -> PSLVERR=1.
